// File: rtl/prover_compute_v_evalbank_pkg.sv
// Shared definitions for the sumcheck evaluation banks: field parameters,
// controller state encoding and the modular adder used by every bank.
package prover_evalbank_pkg;

    // Prime field: the Mersenne prime 2^61 - 1.
    localparam int                 F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_Q     = 61'h1FFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        EVB_IDLE  = 2'd0,
        EVB_ACCUM = 2'd1,
        EVB_OUT   = 2'd2
    } evb_state_t;

    // Modular add of two operands that are both already reduced (< F_Q).
    // One conditional subtract is therefore enough.
    function automatic logic [F_NBITS-1:0] addmod(input logic [F_NBITS-1:0] a,
                                                  input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) begin
            s = s - {1'b0, F_Q};
        end
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/prover_compute_v_evalbank_if.sv
// Batch-input / result-output bundle of the evaluation bank.
interface prover_compute_v_evalbank_if #(
    parameter int nLanes  = 4,
    parameter int nPoints = 4
);
    import prover_evalbank_pkg::*;

    logic [nLanes-1:0]                            lane_valid;
    logic [nLanes-1:0]                            lane_mask;
    logic [nLanes-1:0][nPoints-1:0][F_NBITS-1:0]  lane_val;
    logic                                         in_ready;
    logic                                         clear;
    logic                                         finish;
    logic                                         out_valid;
    logic                                         out_ready;
    logic [nPoints-1:0][F_NBITS-1:0]              out_vals;
    logic                                         busy;

    // Producer / consumer side (gate-bank lanes and the round interpolator).
    modport master (
        output lane_valid, lane_mask, lane_val, clear, finish, out_ready,
        input  in_ready, out_valid, out_vals, busy
    );

    // The evaluation bank itself.
    modport slave (
        input  lane_valid, lane_mask, lane_val, clear, finish, out_ready,
        output in_ready, out_valid, out_vals, busy
    );

endinterface

// File: rtl/prover_compute_v_evalbank_addmod.sv
// Single combinational modular adder, shared by all accumulator points.
module prover_evalbank_addmod
    import prover_evalbank_pkg::*;
(
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic [F_NBITS-1:0] sum
);

    assign sum = addmod(a, b);

endmodule

// File: rtl/prover_compute_v_evalbank.sv
// Lane-reduction and round-accumulation bank: each accepted batch is folded
// into one accumulator per evaluation point, one modular add per cycle, and
// the accumulators are presented (and auto-cleared) on a finish request.
module prover_compute_v_evalbank
    import prover_evalbank_pkg::*;
#(
    parameter int nLanes   = 4,
    parameter int nPoints  = 4,
    parameter int nCntBits = $clog2(nLanes * nPoints)
) (
    input logic                        clk,
    input logic                        rst,
    prover_compute_v_evalbank_if.slave bus
);

    localparam int N_OPS = nLanes * nPoints;
    localparam int PW    = $clog2(nPoints);
    localparam int LW    = (nLanes > 1) ? $clog2(nLanes) : 1;

    evb_state_t                                   state, state_nxt;
    logic                                         fin_pend;
    logic [nCntBits-1:0]                          cnt;
    logic [nLanes-1:0][nPoints-1:0][F_NBITS-1:0]  cap_buf;
    logic [nPoints-1:0][F_NBITS-1:0]              acc;
    logic                                         in_ready;
    logic                                         accept;
    logic                                         last_op;
    logic [PW-1:0]                                p_idx;
    logic [LW-1:0]                                l_idx;
    logic [F_NBITS-1:0]                           sum;

    assign accept  = in_ready && (&bus.lane_valid);
    assign last_op = (state == EVB_ACCUM) && (cnt == nCntBits'(N_OPS - 1));

    // Point-major walk: all lanes of point 0, then all lanes of point 1, ...
    assign p_idx = PW'(int'(cnt) / nLanes);
    assign l_idx = LW'(int'(cnt) % nLanes);

    prover_evalbank_addmod u_addmod (
        .a   (acc[p_idx]),
        .b   (cap_buf[l_idx][p_idx]),
        .sum (sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= EVB_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        state_nxt = state;
        unique case (state)
            EVB_IDLE: begin
                if (accept)                       state_nxt = EVB_ACCUM;
                else if (bus.finish || fin_pend)  state_nxt = EVB_OUT;
            end
            EVB_ACCUM: begin
                if (last_op) state_nxt = (fin_pend || bus.finish) ? EVB_OUT : EVB_IDLE;
            end
            EVB_OUT: begin
                // clear discards the pending result just like a consumed one.
                if (bus.out_ready || bus.clear) state_nxt = EVB_IDLE;
            end
            default: state_nxt = EVB_IDLE;
        endcase
    end

    // Outputs; everything is forced quiet while reset is held.
    always_comb begin
        in_ready      = (state == EVB_IDLE) && !fin_pend && !rst;
        bus.in_ready  = in_ready;
        bus.out_valid = (state == EVB_OUT) && !rst;
        bus.busy      = (state != EVB_IDLE) && !rst;
        bus.out_vals  = rst ? '0 : acc;
    end

    // Counter, pending-finish flag and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            fin_pend <= 1'b0;
            acc      <= '0;
        end else begin
            if (accept)                  cnt <= '0;
            else if (state == EVB_ACCUM) cnt <= cnt + nCntBits'(1);

            // Entering OUT consumes any pending request, including one that
            // arrives in the very cycle of the transition.
            if (state_nxt == EVB_OUT && state != EVB_OUT) fin_pend <= 1'b0;
            else if (bus.finish)                          fin_pend <= 1'b1;

            // A clear coinciding with an accept zeroes first; the batch then
            // sums onto zero during the following ACCUM cycles.
            if (state == EVB_ACCUM)                                 acc[p_idx] <= sum;
            else if (bus.clear || (state == EVB_OUT && bus.out_ready)) acc <= '0;
        end
    end

    // Batch capture with masked lanes forced to zero.
    always_ff @(posedge clk) begin
        // NOTE: the capture buffer is wide storage and is always written before it is read, so it has no reset.
        if (accept) begin
            for (int l = 0; l < nLanes; l++) begin
                cap_buf[l] <= bus.lane_mask[l] ? bus.lane_val[l] : '0;
            end
        end
    end

    // Clear while a batch is being summed would corrupt the result.
    assert property (@(posedge clk) disable iff (rst) !(state == EVB_ACCUM && bus.clear))
        else $error("clear asserted during ACCUM");

endmodule

// File: tb/tb_prover_compute_v_evalbank.sv
// Directed bench for prover_compute_v_evalbank (4 lanes x 4 points).
module tb_prover_compute_v_evalbank;
    import prover_evalbank_pkg::*;

    localparam int NL = 4;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   low;

    prover_compute_v_evalbank_if #(.nLanes(NL), .nPoints(NP)) bus ();

    prover_compute_v_evalbank #(.nLanes(NL), .nPoints(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vals(input string tag, input logic [F_NBITS-1:0] e0, input logic [F_NBITS-1:0] e1,
                              input logic [F_NBITS-1:0] e2, input logic [F_NBITS-1:0] e3);
        logic [F_NBITS-1:0] ep [NP];
        ep = '{e0, e1, e2, e3};
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s_p%0d", tag, p), 64'(bus.out_vals[p]), 64'(ep[p]));
        end
    endtask

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the current lane_val as a full batch; return how many sampled
    // cycles in_ready stayed low afterwards (bounded).
    task automatic send_batch(input logic [NL-1:0] mask, input logic clr, output int low_cycles);
        check("pre_batch_in_ready", 64'(bus.in_ready), 64'd1);
        bus.lane_valid = '1;
        bus.lane_mask  = mask;
        bus.clear      = clr;
        tick();
        bus.lane_valid = '0;
        bus.clear      = 1'b0;
        low_cycles     = 0;
        while (bus.in_ready !== 1'b1 && low_cycles < 40) begin
            low_cycles++;
            tick();
        end
    endtask

    task automatic pulse_finish();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        check("finish_out_valid", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hs_out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("hs_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic fill_ramp();
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < NP; p++)
                bus.lane_val[l][p] = F_NBITS'(10 * l + p);
    endtask

    task automatic fill_const(input logic [F_NBITS-1:0] v);
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < NP; p++)
                bus.lane_val[l][p] = v;
    endtask

    // Global time limit so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus.lane_valid = '0;
        bus.lane_mask  = '0;
        bus.lane_val   = '0;
        bus.clear      = 1'b0;
        bus.finish     = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check_vals("rst_out_vals", 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_busy", 64'(bus.busy), 64'd0);

        // Partial lane_valid is not an accept.
        bus.lane_valid = 4'b0111;
        bus.lane_mask  = '1;
        tick();
        bus.lane_valid = '0;
        check("partial_valid_busy", 64'(bus.busy), 64'd0);

        // Single batch: lane l point p = 10*l + p.
        fill_ramp();
        send_batch(4'hF, 1'b0, low);
        check("single_in_ready_low", 64'(low), 64'd16);
        pulse_finish();
        check("single_busy", 64'(bus.busy), 64'd1);
        check("single_in_ready", 64'(bus.in_ready), 64'd0);
        check_vals("single", 60, 64, 68, 72);
        handshake();

        // Modular wrap: (F_Q-1) + (F_Q-1) + 2 + 2 = 2 mod F_Q.
        for (int p = 0; p < NP; p++) begin
            bus.lane_val[0][p] = F_Q - 1;
            bus.lane_val[1][p] = F_Q - 1;
            bus.lane_val[2][p] = 2;
            bus.lane_val[3][p] = 2;
        end
        send_batch(4'hF, 1'b0, low);
        pulse_finish();
        check_vals("wrap", 2, 2, 2, 2);
        handshake();

        // Mask and accumulation across batches: 4 + 2 = 6.
        fill_const(1);
        send_batch(4'hF, 1'b0, low);
        send_batch(4'b0101, 1'b0, low);
        pulse_finish();
        check_vals("mask_accum", 6, 6, 6, 6);
        handshake();
        pulse_finish();
        check_vals("auto_clear", 0, 0, 0, 0);
        handshake();

        // Finish in the 5th ACCUM cycle: lane l = l+1 gives 10 per point.
        for (int l = 0; l < NL; l++)
            for (int p = 0; p < NP; p++)
                bus.lane_val[l][p] = F_NBITS'(l + 1);
        check("busyfin_pre_in_ready", 64'(bus.in_ready), 64'd1);
        bus.lane_valid = '1;
        bus.lane_mask  = '1;
        tick();
        bus.lane_valid = '0;
        repeat (4) tick();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        repeat (10) tick();
        check("busyfin_last_accum_out_valid", 64'(bus.out_valid), 64'd0);
        check("busyfin_last_accum_busy", 64'(bus.busy), 64'd1);
        tick();
        check("busyfin_out_valid", 64'(bus.out_valid), 64'd1);
        check_vals("busyfin", 10, 10, 10, 10);
        handshake();

        // Accept + clear in one IDLE cycle: 20 is discarded, result is 4.
        fill_const(5);
        send_batch(4'hF, 1'b0, low);
        fill_const(1);
        send_batch(4'hF, 1'b1, low);
        pulse_finish();
        check_vals("accept_clear", 4, 4, 4, 4);
        handshake();

        // Output backpressure for 10 cycles, then clear discards the result.
        fill_ramp();
        send_batch(4'hF, 1'b0, low);
        pulse_finish();
        for (int i = 0; i < 10; i++) begin
            check_vals($sformatf("bp%0d", i), 60, 64, 68, 72);
            check($sformatf("bp%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("bp%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_out_valid_drop", 64'(bus.out_valid), 64'd0);
        pulse_finish();
        check_vals("after_clear", 0, 0, 0, 0);
        handshake();

        // Reset for two cycles in the middle of ACCUM.
        fill_ramp();
        bus.lane_valid = '1;
        bus.lane_mask  = '1;
        tick();
        bus.lane_valid = '0;
        repeat (3) tick();
        check("midrst_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_release_busy", 64'(bus.busy), 64'd0);
        check("midrst_release_out_valid", 64'(bus.out_valid), 64'd0);
        pulse_finish();
        check_vals("midrst_zero", 0, 0, 0, 0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
